// File: rtl/nx_stream_arb_multi.sv
// Multi-input stream arbiter: fixed or round-robin grant, message lock until the
// last beat, and a one-entry output register that sustains one beat per cycle.
module nx_stream_arb_multi #(
  parameter int    STREAM_WIDTH = 32,
  parameter int    INPUTS       = 4,
  parameter string PRIO_MODE    = "round_robin",
  localparam int   SRC_W        = (INPUTS > 1) ? $clog2(INPUTS) : 1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [INPUTS-1:0][STREAM_WIDTH-1:0]  in_data_i,
  input  logic [INPUTS-1:0]                    in_last_i,
  input  logic [INPUTS-1:0]                    in_valid_i,
  output logic [INPUTS-1:0]                    in_ready_o,
  input  logic [INPUTS-1:0]                    mask_i,
  output logic [STREAM_WIDTH-1:0]              out_data_o,
  output logic                                 out_last_o,
  output logic [SRC_W-1:0]                     out_src_o,
  output logic                                 out_valid_o,
  input  logic                                 out_ready_i,
  output logic [2*SRC_W:0]                     dbg_state_o
);

  localparam bit FIXED_MODE = (PRIO_MODE == "fixed");

  logic                    lock_q, lock_d;
  logic [SRC_W-1:0]        locked_src_q, locked_src_d;
  logic [SRC_W-1:0]        ptr_q, ptr_d;
  logic [STREAM_WIDTH-1:0] out_data_q, out_data_d;
  logic                    out_last_q, out_last_d;
  logic [SRC_W-1:0]        out_src_q, out_src_d;
  logic                    out_valid_q, out_valid_d;

  logic [INPUTS-1:0]       elig;
  logic [SRC_W-1:0]        grant;
  logic [SRC_W-1:0]        cand;
  logic                    grant_valid;
  logic                    load;
  logic                    accept;

  // Grant selection. Loops run in reverse so the last hit written is the first
  // one in search order.
  always_comb begin
    elig        = in_valid_i & mask_i;
    grant       = '0;
    grant_valid = 1'b0;
    cand        = '0;
    if (lock_q) begin
      grant       = locked_src_q;
      grant_valid = in_valid_i[locked_src_q];
    end else if (FIXED_MODE) begin
      for (int i = INPUTS - 1; i >= 0; i--) begin
        if (elig[i]) begin
          grant       = SRC_W'(i);
          grant_valid = 1'b1;
        end
      end
    end else begin
      for (int k = INPUTS; k >= 1; k--) begin
        cand = SRC_W'((int'(ptr_q) + k) % INPUTS);
        if (elig[cand]) begin
          grant       = cand;
          grant_valid = 1'b1;
        end
      end
    end
  end

  // Handshake: a beat moves on input i when in_valid_i[i] && in_ready_o[i] at a
  // rising edge; out_valid_o/out_ready_i follow the same rule downstream, and
  // ready never depends on a valid being held high only because ready is high.
  always_comb begin
    load         = !out_valid_q || out_ready_i;
    accept       = load && grant_valid && !rst_i;
    lock_d       = lock_q;
    locked_src_d = locked_src_q;
    ptr_d        = ptr_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    out_src_d    = out_src_q;
    out_valid_d  = out_valid_q;
    in_ready_o   = '0;
    if (accept) begin
      in_ready_o[grant] = 1'b1;
      if (in_last_i[grant]) begin
        lock_d = 1'b0;
        ptr_d  = grant;
      end else begin
        lock_d       = 1'b1;
        locked_src_d = grant;
      end
    end
    if (load) begin
      out_valid_d = accept;
      if (accept) begin
        out_data_d = in_data_i[grant];
        out_last_d = in_last_i[grant];
        out_src_d  = grant;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock_q       <= 1'b0;
      locked_src_q <= '0;
      ptr_q        <= SRC_W'(INPUTS - 1);
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      out_src_q    <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      lock_q       <= lock_d;
      locked_src_q <= locked_src_d;
      ptr_q        <= ptr_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      out_src_q    <= out_src_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign out_data_o  = out_data_q;
  assign out_last_o  = out_last_q;
  assign out_src_o   = out_src_q;
  assign out_valid_o = out_valid_q;
  // {lock, locked_src, ptr}
  assign dbg_state_o = {lock_q, locked_src_q, ptr_q};

endmodule

// File: tb/tb_nx_stream_arb_multi.sv
// Bench for nx_stream_arb_multi: one round-robin and one fixed-priority instance,
// per-source beat queues feeding the inputs and a scoreboard on the outputs.
module tb_nx_stream_arb_multi;
  localparam int W = 32;
  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]               rst;
  logic [1:0][N-1:0][W-1:0] in_data;
  logic [1:0][N-1:0]        in_last;
  logic [1:0][N-1:0]        in_valid;
  logic [1:0][N-1:0]        in_ready;
  logic [1:0][N-1:0]        mask;
  logic [1:0][W-1:0]        out_data;
  logic [1:0]               out_last;
  logic [1:0][1:0]          out_src;
  logic [1:0]               out_valid;
  logic [1:0]               out_ready;
  logic [1:0][4:0]          dbg;
  logic [1:0][N-1:0]        acc;

  logic [W:0]   src_q [2][N][$];   // {last, data}
  logic [W+2:0] exp_q [2][$];      // {src, last, data}
  int n_checks = 0;
  int n_fail   = 0;

  nx_stream_arb_multi #(.STREAM_WIDTH(W), .INPUTS(N), .PRIO_MODE("round_robin")) dut_rr (
    .clk_i(clk), .rst_i(rst[0]), .in_data_i(in_data[0]), .in_last_i(in_last[0]),
    .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]), .mask_i(mask[0]),
    .out_data_o(out_data[0]), .out_last_o(out_last[0]), .out_src_o(out_src[0]),
    .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]), .dbg_state_o(dbg[0])
  );

  nx_stream_arb_multi #(.STREAM_WIDTH(W), .INPUTS(N), .PRIO_MODE("fixed")) dut_fx (
    .clk_i(clk), .rst_i(rst[1]), .in_data_i(in_data[1]), .in_last_i(in_last[1]),
    .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]), .mask_i(mask[1]),
    .out_data_o(out_data[1]), .out_last_o(out_last[1]), .out_src_o(out_src[1]),
    .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]), .dbg_state_o(dbg[1])
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic put(input int j, input int s, input logic last, input logic [W-1:0] d);
    src_q[j][s].push_back({last, d});
  endtask

  task automatic want(input int j, input logic [1:0] s, input logic last, input logic [W-1:0] d);
    exp_q[j].push_back({s, last, d});
  endtask

  task automatic wait_out(input int j, input int budget);
    for (int c = 0; c < budget && !out_valid[j]; c++) tick();
    chk($sformatf("wait_valid%0d", j), 32'(out_valid[j]), 32'd1);
  endtask

  task automatic drain(input int j);
    for (int c = 0; c < 60 && exp_q[j].size() > 0; c++) tick();
    chk($sformatf("drain%0d", j), 32'(exp_q[j].size()), 32'd0);
    tick();
    tick();
    tick();
  endtask

  // Source driver: sample handshakes well before the edge, then present queue heads.
  initial begin
    in_valid = '0;
    in_data  = '0;
    in_last  = '0;
    acc      = '0;
    forever begin
      @(negedge clk);
      #3;
      acc = in_valid & in_ready;
      @(posedge clk);
      #1;
      for (int j = 0; j < 2; j++) begin
        for (int i = 0; i < N; i++) begin
          if (acc[j][i] && src_q[j][i].size() > 0) void'(src_q[j][i].pop_front());
          if (src_q[j][i].size() > 0) begin
            in_valid[j][i] = 1'b1;
            {in_last[j][i], in_data[j][i]} = src_q[j][i][0];
          end else begin
            in_valid[j][i] = 1'b0;
          end
        end
      end
    end
  end

  // Output monitor: every presented-and-taken beat is compared with the queue head.
  always @(negedge clk) begin
    logic [W+2:0] e;
    #2;
    for (int j = 0; j < 2; j++) begin
      if (out_valid[j] && out_ready[j]) begin
        if (exp_q[j].size() == 0) begin
          chk($sformatf("unexpected_beat%0d", j), out_data[j], 32'hxxxx_xxxx);
        end else begin
          e = exp_q[j].pop_front();
          chk($sformatf("beat_src%0d", j), 32'(out_src[j]), 32'(e[W+2:W+1]));
          chk($sformatf("beat_last%0d", j), 32'(out_last[j]), 32'(e[W]));
          chk($sformatf("beat_data%0d", j), out_data[j], e[W-1:0]);
        end
      end
    end
  end

  initial begin
    rst       = '1;
    out_ready = '1;
    mask      = '1;

    // Round robin over four single-beat sources, source 0 has a second beat
    put(0, 0, 1'b1, 32'h100);
    put(0, 1, 1'b1, 32'h101);
    put(0, 2, 1'b1, 32'h102);
    put(0, 3, 1'b1, 32'h103);
    put(0, 0, 1'b1, 32'h104);
    want(0, 2'd0, 1'b1, 32'h100);
    want(0, 2'd1, 1'b1, 32'h101);
    want(0, 2'd2, 1'b1, 32'h102);
    want(0, 2'd3, 1'b1, 32'h103);
    want(0, 2'd0, 1'b1, 32'h104);
    tick();
    tick();
    tick();
    chk("rst_valid", 32'(out_valid[0]), 32'd0);
    chk("rst_data", out_data[0], 32'd0);
    chk("rst_last", 32'(out_last[0]), 32'd0);
    chk("rst_src", 32'(out_src[0]), 32'd0);
    chk("rst_ready", 32'(in_ready[0]), 32'd0);
    chk("rst_state", 32'(dbg[0]), 32'b0_00_11);
    chk("rst_valid_fx", 32'(out_valid[1]), 32'd0);
    rst = '0;
    wait_out(0, 10);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("rr_nobubble%0d", k), 32'(out_valid[0]), 32'd1);
      tick();
    end
    drain(0);

    // Three-beat message from source 1 holds off source 2
    put(0, 1, 1'b0, 32'h110);
    put(0, 1, 1'b0, 32'h111);
    put(0, 1, 1'b1, 32'h112);
    put(0, 2, 1'b1, 32'h120);
    want(0, 2'd1, 1'b0, 32'h110);
    want(0, 2'd1, 1'b0, 32'h111);
    want(0, 2'd1, 1'b1, 32'h112);
    want(0, 2'd2, 1'b1, 32'h120);
    for (int c = 0; c < 30 && exp_q[0].size() > 0; c++) begin
      tick();
      if (in_valid[0][1]) begin
        chk("lock_rdy2", 32'(in_ready[0][2]), 32'd0);
        chk("lock_rdy1", 32'(in_ready[0][1]), 32'd1);
      end
    end
    drain(0);

    // Backpressure: held output, no input accepted, then one beat per cycle
    out_ready[0] = 1'b0;
    put(0, 0, 1'b1, 32'hDEADBEEF);
    put(0, 0, 1'b1, 32'h11);
    put(0, 0, 1'b1, 32'h22);
    want(0, 2'd0, 1'b1, 32'hDEADBEEF);
    want(0, 2'd0, 1'b1, 32'h11);
    want(0, 2'd0, 1'b1, 32'h22);
    wait_out(0, 10);
    for (int k = 0; k < 5; k++) begin
      chk("hold_valid", 32'(out_valid[0]), 32'd1);
      chk("hold_data", out_data[0], 32'hDEADBEEF);
      chk("hold_last", 32'(out_last[0]), 32'd1);
      chk("hold_src", 32'(out_src[0]), 32'd0);
      chk("hold_ready", 32'(in_ready[0]), 32'd0);
      tick();
    end
    out_ready[0] = 1'b1;
    tick();
    chk("resume1_valid", 32'(out_valid[0]), 32'd1);
    chk("resume1_data", out_data[0], 32'h11);
    tick();
    chk("resume2_valid", 32'(out_valid[0]), 32'd1);
    chk("resume2_data", out_data[0], 32'h22);
    drain(0);

    // Locked source 2 stalls; source 0 must wait for the message to finish
    put(0, 2, 1'b0, 32'h200);
    put(0, 0, 1'b1, 32'h0A0);
    want(0, 2'd2, 1'b0, 32'h200);
    want(0, 2'd2, 1'b0, 32'h201);
    want(0, 2'd2, 1'b1, 32'h202);
    want(0, 2'd0, 1'b1, 32'h0A0);
    for (int c = 0; c < 20 && src_q[0][2].size() > 0; c++) tick();
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_ready", 32'(in_ready[0]), 32'd0);
    end
    put(0, 2, 1'b0, 32'h201);
    put(0, 2, 1'b1, 32'h202);
    drain(0);

    // Reset after the first beat of a four-beat message from source 3
    put(0, 3, 1'b0, 32'h300);
    put(0, 3, 1'b0, 32'h301);
    put(0, 3, 1'b0, 32'h302);
    put(0, 3, 1'b1, 32'h303);
    want(0, 2'd3, 1'b0, 32'h300);
    for (int c = 0; c < 20 && src_q[0][3].size() > 3; c++) tick();
    rst[0] = 1'b1;
    put(0, 1, 1'b1, 32'h1B0);
    want(0, 2'd1, 1'b1, 32'h1B0);
    want(0, 2'd3, 1'b0, 32'h301);
    want(0, 2'd3, 1'b0, 32'h302);
    want(0, 2'd3, 1'b1, 32'h303);
    tick();
    chk("midrst_valid", 32'(out_valid[0]), 32'd0);
    chk("midrst_ready", 32'(in_ready[0]), 32'd0);
    chk("midrst_state", 32'(dbg[0]), 32'b0_00_11);
    chk("midrst_data", out_data[0], 32'd0);
    rst[0] = 1'b0;
    tick();
    chk("postrst_valid", 32'(out_valid[0]), 32'd1);
    chk("postrst_src", 32'(out_src[0]), 32'd1);
    drain(0);

    // Fixed priority: source 0 wins until masked, then source 3
    for (int k = 0; k < 5; k++) put(1, 0, 1'b1, 32'hF0 + 32'(k));
    put(1, 3, 1'b1, 32'hE0);
    put(1, 3, 1'b1, 32'hE1);
    want(1, 2'd0, 1'b1, 32'hF0);
    want(1, 2'd0, 1'b1, 32'hF1);
    want(1, 2'd0, 1'b1, 32'hF2);
    want(1, 2'd3, 1'b1, 32'hE0);
    want(1, 2'd3, 1'b1, 32'hE1);
    want(1, 2'd0, 1'b1, 32'hF3);
    want(1, 2'd0, 1'b1, 32'hF4);
    for (int c = 0; c < 20 && src_q[1][0].size() > 2; c++) tick();
    mask[1] = 4'b1110;
    tick();
    chk("fx_masked_src", 32'(out_src[1]), 32'd3);
    chk("fx_masked_data", out_data[1], 32'hE0);
    for (int c = 0; c < 20 && src_q[1][3].size() > 0; c++) tick();
    mask[1] = 4'b1111;
    drain(1);

    chk("sources_empty", 32'(src_q[0][3].size() + src_q[1][0].size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nx_stream_arb_multi.md
NX_STREAM_ARB_MULTI -- requirements
Module: nx_stream_arb_multi

Interface
REQ-001 SHALL have parameter STREAM_WIDTH, default 32, giving the data width per beat.
REQ-002 SHALL have parameter INPUTS, default 4, giving the number of inbound streams; legal range is 1..16.
REQ-003 SHALL have parameter PRIO_MODE, default "round_robin", selecting "round_robin" or "fixed" arbitration.
REQ-004 SHALL define SRC_W = max(1, $clog2(INPUTS)).
REQ-005 SHALL have port clk_i, input, width 1: the single clock.
REQ-006 SHALL have port rst_i, input, width 1: reset, synchronous and active-high.
REQ-007 SHALL have port in_data_i, input, width [INPUTS-1:0][STREAM_WIDTH-1:0]: inbound beat data.
REQ-008 SHALL have port in_last_i, input, width [INPUTS-1:0]: final beat of a message.
REQ-009 SHALL have port in_valid_i, input, width [INPUTS-1:0]: inbound beat valid.
REQ-010 SHALL have port in_ready_o, output, width [INPUTS-1:0]: inbound beat accepted.
REQ-011 SHALL have port mask_i, input, width [INPUTS-1:0]: per-source enable, where 1 means the source is eligible.
REQ-012 SHALL have port out_data_o, output, width STREAM_WIDTH: arbitrated data.
REQ-013 SHALL have port out_last_o, output, width 1: arbitrated last flag.
REQ-014 SHALL have port out_src_o, output, width SRC_W: index of the source of the current output beat.
REQ-015 SHALL have port out_valid_o, output, width 1: output beat valid.
REQ-016 SHALL have port out_ready_i, input, width 1: downstream ready.

Function
REQ-017 SHALL define a beat as accepted on input i when in_valid_i[i] and in_ready_o[i] are both high at a rising edge of clk_i.
REQ-018 SHALL hold the output in a one-entry register, so input-to-output latency is exactly 1 cycle.
REQ-019 SHALL define load = !out_valid_o || out_ready_i; this sustains one beat per cycle while out_ready_i stays high.
REQ-020 SHALL drive in_ready_o[i] = load && (grant == i) && grant_valid; at most one bit of in_ready_o SHALL be high in any cycle.
REQ-021 SHALL form grant combinationally from the current in_valid_i, mask_i, the lock state and the round-robin pointer.
REQ-022 SHALL, when unlocked, consider as eligible only sources with in_valid_i & mask_i set.
REQ-023 SHALL, in "fixed" mode, grant the lowest eligible index.
REQ-024 SHALL, in "round_robin" mode, grant the first eligible index searching from ptr+1 upward and wrapping modulo INPUTS.
REQ-025 SHALL, when no source is eligible, drive grant_valid low and assert no in_ready_o bit.
REQ-026 SHALL set the lock, registering locked_src = grant, when a beat with in_last_i = 0 is accepted.
REQ-027 SHALL, while locked, force grant to locked_src irrespective of mask_i and of the other sources' valids, so a message is never interleaved or broken.
REQ-028 SHALL, while locked with in_valid_i[locked_src] low, assert no in_ready_o bit and insert no other source's beat.
REQ-029 SHALL clear the lock on acceptance of a beat with in_last_i = 1, so the next cycle arbitrates afresh.
REQ-030 SHALL update ptr to the granted index only when a beat with in_last_i = 1 is accepted; ptr is unused in "fixed" mode.
REQ-031 SHALL, on load with an accepted beat, register out_data_o, out_last_o and out_src_o from the granted source and set out_valid_o = 1.
REQ-032 SHALL, on load with no accepted beat, set out_valid_o = 0 while out_data_o, out_last_o and out_src_o hold their values.
REQ-033 SHALL keep out_data_o, out_last_o and out_src_o stable while out_valid_o = 1 and out_ready_i = 0.
REQ-034 SHALL, when a last beat leaves and a new source's beat enters in the same cycle, accept both with no bubble.
REQ-035 SHALL, when INPUTS = 1, degenerate to a registered pass-through with out_src_o = 0.

Reset
REQ-036 SHALL, with rst_i high at a clock edge, set out_valid_o = 0, out_data_o = 0, out_last_o = 0, out_src_o = 0, lock = 0 and ptr = INPUTS-1, so the first round-robin search starts at index 0.
REQ-037 SHALL hold in_ready_o at all zeros in any cycle where rst_i is high.
REQ-038 SHALL, on reset mid-message, discard the lock and any pending output beat; the next grant after reset follows REQ-036.

Verification
REQ-039 SHALL cover this scenario: INPUTS = 4, round_robin, all four inputs valid with single-beat messages (last = 1), out_ready_i = 1 -> out_src_o sequence 0,1,2,3,0 on consecutive cycles with no bubbles.
REQ-040 SHALL cover this scenario: source 1 sends a 3-beat message (last on beat 3) while source 2 is valid throughout -> outputs src 1,1,1 then src 2, with in_ready_o[2] = 0 during all of source 1's beats.
REQ-041 SHALL cover this scenario: fixed mode, sources 0 and 3 continuously valid -> out_src_o stays 0; masking bit 0 -> grants move to source 3 on the next cycle.
REQ-042 SHALL cover this scenario: out_ready_i = 0 for 5 cycles with out_valid_o = 1 and data 0xDEADBEEF -> data, last and src held, no in_ready_o asserted; on release, 1 beat per cycle resumes.
REQ-043 SHALL cover this scenario: locked on source 2 with in_valid_i[2] dropped for 3 cycles while source 0 is valid -> no beat from source 0; source 2 resumes and completes first.
REQ-044 SHALL cover this scenario: rst_i pulsed after beat 1 of a 4-beat message from source 3 -> out_valid_o = 0 and lock cleared; the next grant goes to the lowest eligible index from 0.
